laplace_tap_accumulator: RTL and testbench

//  Downstream consumer of the 8-bit ripple-carry sum stage. Takes a serial stream of
//  5 pixels per window (center, up, down, left, right) and accumulates the 4-neighbour

---
 rtl/laplace_tap_accumulator_if.sv | 24 ++
 rtl/laplace_tap_accumulator.sv | 107 ++++++++++
 tb/tb_laplace_tap_accumulator.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/laplace_tap_accumulator_if.sv
// Valid/ready bus for the Laplacian tap accumulator: pixel stream in, edge pixel out.
// master drives the input beats and out_ready; slave is the accumulator.
interface laplace_tap_accumulator_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_pixel;
  logic              in_first;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_pixel;
  logic              err;

  modport master (
    output in_valid, in_pixel, in_first, out_ready,
    input  in_ready, out_valid, out_pixel, err
  );

  modport slave (
    input  in_valid, in_pixel, in_first, out_ready,
    output in_ready, out_valid, out_pixel, err
  );
endinterface

// File: rtl/laplace_tap_accumulator.sv
// Serial 5-tap 4-neighbour Laplacian (4*C - U - D - L - R) with one clamped pixel per window.
// Build option LAPLACE_ABS_EN: output min(|acc|, max pixel) instead of clamping negatives to 0.
module laplace_tap_accumulator #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 11,
  parameter int TAPS   = 5
) (
  input logic                      clk,
  input logic                      rst,
  laplace_tap_accumulator_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for tap 0 (center beat, in_first=1)
  // ACC   | subtracting neighbour taps 1..TAPS-1
  // OUT   | result presented, held until out_ready
  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam int                      CNT_W    = $clog2(TAPS);
  localparam logic [CNT_W-1:0]        CNT_LOAD = CNT_W'(TAPS - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'((1 << DATA_W) - 1);

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_tap0, acc_sub;
  logic [CNT_W-1:0]        taps_left_q, taps_left_d;
  logic [DATA_W-1:0]       pix_q, pix_d;
  logic                    err_q, err_d;
  logic                    in_ready, accept;

  function automatic logic [DATA_W-1:0] clamp(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] m;
`ifdef LAPLACE_ABS_EN
    m = a[ACC_W-1] ? -a : a;
`else
    m = a[ACC_W-1] ? '0 : a;
`endif
    if (m > PIX_MAX) clamp = '1;
    else             clamp = m[DATA_W-1:0];
  endfunction

  assign acc_tap0 = $signed({{(ACC_W-DATA_W-2){1'b0}}, bus.in_pixel, 2'b00});
  assign acc_sub  = acc_q - $signed({{(ACC_W-DATA_W){1'b0}}, bus.in_pixel});

  assign in_ready      = !rst && (state_q != OUT);
  assign accept        = bus.in_valid && in_ready;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_pixel = pix_q;
  assign bus.err       = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      taps_left_q <= '0;
      pix_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      taps_left_q <= taps_left_d;
      pix_q       <= pix_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    taps_left_d = taps_left_q;
    pix_d       = pix_q;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.in_first) begin
            acc_d       = acc_tap0;
            taps_left_d = CNT_LOAD;
            state_d     = ACC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ACC: begin
        if (accept) begin
          // a new center mid-window restarts the window on this beat
          if (bus.in_first) begin
            acc_d       = acc_tap0;
            taps_left_d = CNT_LOAD;
            err_d       = 1'b1;
          end else begin
            acc_d       = acc_sub;
            taps_left_d = taps_left_q - CNT_W'(1);
            if (taps_left_q == CNT_W'(1)) begin
              pix_d   = clamp(acc_sub);
              state_d = OUT;
            end
          end
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_laplace_tap_accumulator.sv
// Self-checking bench for laplace_tap_accumulator: fixed vector table, corner sequences,
// and randomized traffic against a window-level reference model.
module tb_laplace_tap_accumulator;
  localparam int DATA_W = 8;

`ifdef LAPLACE_ABS_EN
  localparam int T3_RES = 200;
`else
  localparam int T3_RES = 0;
`endif

  typedef struct {
    bit r, v; int pix; bit f, o;
    bit ev; int ep; bit ee, er;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  laplace_tap_accumulator_if #(.DATA_W(DATA_W)) bus ();

  laplace_tap_accumulator #(.DATA_W(DATA_W), .ACC_W(11), .TAPS(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // reference model: accepted beats of the open window, plus the pending result
  int win[$];
  bit m_pend = 1'b0;
  int m_pix  = 0;
  bit m_err  = 1'b0;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_result(input int q[$]);
    int a;
    a = 4 * q[0];
    for (int i = 1; i < q.size(); i++) a -= q[i];
`ifdef LAPLACE_ABS_EN
    if (a < 0) a = -a;
`else
    if (a < 0) a = 0;
`endif
    if (a > 255) a = 255;
    return a;
  endfunction

  task automatic model_edge(input bit r, input bit v, input int pix, input bit f, input bit o);
    if (r) begin
      win.delete();
      m_pend = 1'b0;
      m_pix  = 0;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b0;
      if (m_pend) begin
        if (o) m_pend = 1'b0;
      end else if (v) begin
        if (f) begin
          if (win.size() > 0) m_err = 1'b1;
          win.delete();
          win.push_back(pix);
        end else if (win.size() == 0) begin
          m_err = 1'b1;
        end else begin
          win.push_back(pix);
          if (win.size() == 5) begin
            m_pix  = ref_result(win);
            m_pend = 1'b1;
            win.delete();
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input int pix, input bit f, input bit o);
    rst           = r;
    bus.in_valid  = v;
    bus.in_pixel  = pix[7:0];
    bus.in_first  = f;
    bus.out_ready = o;
  endtask

  // one clock with model-checked outputs sampled 1ns after the edge
  task automatic cycle(input bit r, input bit v, input int pix, input bit f, input bit o);
    drive(r, v, pix, f, o);
    @(posedge clk);
    model_edge(r, v, pix, f, o);
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_pend));
    check("out_pixel", 32'(bus.out_pixel), 32'(m_pix));
    check("err",       32'(bus.err),       32'(m_err));
    check("in_ready",  32'(bus.in_ready),  32'(!m_pend && !r));
  endtask

  function automatic void add(input bit r, input bit v, input int pix, input bit f, input bit o,
                              input bit ev, input int ep, input bit ee, input bit er);
    vec_t t;
    t = '{r: r, v: v, pix: pix, f: f, o: o, ev: ev, ep: ep, ee: ee, er: er};
    tbl.push_back(t);
  endfunction

  function automatic void add_window(input int c, input int n, input int res, input int prev);
    add(0, 1, c, 1, 1, 0, prev, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 1, n, 0, 1, 0, prev, 0, 1);
    add(0, 1, n, 0, 1, 1, res, 0, 0);
    add(0, 0, 0, 0, 1, 0, res, 0, 1);
  endfunction

  initial begin
    int errs;
    drive(1, 0, 0, 0, 1);

    add(1, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add_window(10, 10, 0, 0);
    add_window(100, 0, 255, 0);
    add_window(0, 50, T3_RES, 255);
    add(0, 1, 77, 0, 1, 0, T3_RES, 1, 1);
    add(0, 0, 0, 0, 1, 0, T3_RES, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].pix, tbl[i].f, tbl[i].o);
      @(posedge clk);
      model_edge(tbl[i].r, tbl[i].v, tbl[i].pix, tbl[i].f, tbl[i].o);
      #1;
      check("tbl out_valid", 32'(bus.out_valid), 32'(tbl[i].ev));
      check("tbl out_pixel", 32'(bus.out_pixel), 32'(tbl[i].ep));
      check("tbl err",       32'(bus.err),       32'(tbl[i].ee));
      check("tbl in_ready",  32'(bus.in_ready),  32'(tbl[i].er));
    end

    // backpressure: result held 3 cycles, accepted on the 4th
    cycle(0, 1, 60, 1, 0);
    cycle(0, 1, 10, 0, 0);
    cycle(0, 1, 20, 0, 0);
    cycle(0, 1, 30, 0, 0);
    cycle(0, 1, 40, 0, 0);
    check("bp first valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 99, 1, 0);
      check("bp held pixel", 32'(bus.out_pixel), 32'd140);
      check("bp in_ready",   32'(bus.in_ready),  32'd0);
    end
    cycle(0, 0, 0, 0, 1);
    check("bp released", 32'(bus.out_valid), 32'd0);

    // restart mid-window on tap 2
    errs = 0;
    cycle(0, 1, 7, 1, 1);  errs += int'(bus.err);
    cycle(0, 1, 9, 0, 1);  errs += int'(bus.err);
    cycle(0, 1, 5, 1, 1);  errs += int'(bus.err);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 1, 0, 1);
      errs += int'(bus.err);
    end
    check("restart err count", 32'(errs), 32'd1);
    check("restart pixel",     32'(bus.out_pixel), 32'd16);
    cycle(0, 0, 0, 0, 1);

    // reset after tap 3 discards the window silently
    errs = 0;
    cycle(0, 1, 9, 1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 1, 2, 0, 1);
    cycle(1, 1, 2, 0, 1);
    check("rst in_ready", 32'(bus.in_ready), 32'd0);
    cycle(0, 0, 0, 0, 1);
    check("rst no stale", 32'(bus.out_valid), 32'd0);
    cycle(0, 1, 3, 1, 1);  errs += int'(bus.err);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 1, 0, 0, 1);
      errs += int'(bus.err);
    end
    check("rst clean pixel", 32'(bus.out_pixel), 32'd12);
    check("rst no err",      32'(errs), 32'd0);
    cycle(0, 0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      bit r, v, f, o;
      int pix;
      r   = ($urandom % 300) == 0;
      v   = ($urandom % 4) != 0;
      o   = ($urandom % 3) != 0;
      f   = (win.size() == 0) ? (($urandom % 8) != 0) : (($urandom % 12) == 0);
      pix = (($urandom % 4) == 0) ? ((($urandom % 2) == 0) ? 0 : 255) : int'($urandom % 256);
      cycle(r, v, pix, f, o);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
